// File: rtl/drum_audio_pkg.sv
// Shared types and constants for the drum solver audio sink.
package drum_audio_pkg;

    localparam int AMP_W       = 18;    // signed 1.17 amplitude from the solver
    localparam int PCM_W       = 16;    // signed PCM word to the audio core
    localparam int DIV_DEFAULT = 1042;  // 50 MHz / 48 kHz, rounded

    localparam logic signed [PCM_W-1:0] PCM_MAX = 16'sh7FFF;
    localparam logic signed [PCM_W-1:0] PCM_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PRESENT
    } state_e;

endpackage

// File: rtl/drum_sample_fifo.sv
// Synchronous FIFO for solver amplitudes. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate count.
module drum_sample_fifo
    import drum_audio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             push,
    input  logic [AMP_W-1:0] push_data,
    input  logic             pop,
    output logic [AMP_W-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [AMP_W-1:0] mem_q [DEPTH];

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head_data = mem_q[rd_ptr_q[PW-1:0]];

    // Next pointer values; a push when full or a pop when empty is ignored
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    // Storage write port
    // NOTE: the array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_50) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

    // Pointer registers
    always_ff @(posedge clk_50 or negedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/drum_audio_out.sv
// Sink end of the drum solver amplitude stream: buffers 1.17 samples and
// presents one 16-bit PCM word per audio tick to the Avalon-ST audio core.
// Underrun repeats the last sample; overflow drops the incoming one.
module drum_audio_out
    import drum_audio_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DIV        = DIV_DEFAULT,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                    clk_50,
    input  logic                    reset,
    input  logic signed [AMP_W-1:0] amp_in,
    input  logic                    amp_valid,
    output logic                    amp_ready,
    input  logic                    audio_ready,
    output logic signed [PCM_W-1:0] audio_left_data,
    output logic signed [PCM_W-1:0] audio_right_data,
    output logic                    audio_valid,
    output logic                    overflow,
    output logic [15:0]             underrun_cnt
);

    localparam int CW = $clog2(DIV);
    localparam int SW = AMP_W + GAIN_SHIFT;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    tick;
    state_e                  state_q, state_d;
    logic                    pend_q, pend_d;
    logic                    valid_q, valid_d;
    logic signed [AMP_W-1:0] sample_q, sample_d;
    logic [15:0]             underrun_q, underrun_d;
    logic                    overflow_q, overflow_d;

    logic                    pop;
    logic [AMP_W-1:0]        fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;

    logic signed [SW-1:0]    scaled;
    logic signed [PCM_W-1:0] pcm;

    drum_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_50    (clk_50),
        .reset     (reset),
        .push      (amp_valid),
        .push_data (amp_in),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Backpressure reflects start-of-cycle occupancy, so a same-cycle pop
    // never makes room for a push.
    assign amp_ready = !fifo_full;

    // Free-running audio tick divider, pulsing on wrap
    always_comb begin
        tick  = (cnt_q == CW'(DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // Sample scheduling FSM, one-deep tick memory and status counters
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        valid_d    = valid_q;
        sample_d   = sample_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q | (amp_valid & fifo_full);
        pop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tick || pend_q) begin
                    state_d = LOAD;
                    pend_d  = 1'b0;
                end
            end
            LOAD: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    sample_d = fifo_head;
                end else if (underrun_q != 16'hFFFF) begin
                    underrun_d = underrun_q + 16'd1;
                end
                valid_d = 1'b1;
                state_d = PRESENT;
                if (tick) begin
                    pend_d = 1'b1;
                end
            end
            PRESENT: begin
                if (tick) begin
                    pend_d = 1'b1;
                end
                if (audio_ready) begin
                    valid_d = 1'b0;
                    if (pend_q || tick) begin
                        // Serve the remembered tick; a tick landing now stays queued.
                        state_d = LOAD;
                        pend_d  = pend_q && tick;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gain, drop two fraction bits, then clamp into the PCM range
    always_comb begin
        scaled = (SW'(sample_q) <<< GAIN_SHIFT) >>> 2;
        if (scaled[SW-1:PCM_W-1] == {(SW-PCM_W+1){scaled[PCM_W-1]}}) begin
            pcm = scaled[PCM_W-1:0];
        end else begin
            pcm = scaled[SW-1] ? PCM_MIN : PCM_MAX;
        end
    end

    // All block state; reset also drops audio_valid at once
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            valid_q    <= 1'b0;
            sample_q   <= '0;
            underrun_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            sample_q   <= sample_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign audio_valid      = valid_q;
    assign audio_left_data  = pcm;
    assign audio_right_data = pcm;
    assign overflow         = overflow_q;
    assign underrun_cnt     = underrun_q;

endmodule
